serial_bus_master: RTL and testbench



---
 rtl/serial_bus_master.sv | 238 +++++++++++++++++++++++
 tb/tb_serial_bus_master.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_master.sv
// UART-driven bus initiator: decodes read/write command frames, performs the bus access, replies over UART.
// Optional trailing XOR checksum byte per frame is enabled with SERIAL_BUS_MASTER_CHECKSUM_EN.
module serial_bus_master #(
   parameter int TIMEOUT_CYCLES = 1200000,
   parameter int READ_LATENCY   = 1
) (
   input  logic        clk,
   input  logic        reset_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        rx_rd_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_wr_o,
   input  logic        tx_busy_i,
   output logic        bus_req_o,
   output logic [31:0] addr_o,
   output logic        we_o,
   output logic [3:0]  wr_mask_o,
   output logic [31:0] data_out_o,
   input  logic [31:0] data_in_i,
   output logic        busy_o
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [7:0] CMD_WR = 8'h57;
   localparam logic [7:0] CMD_RD = 8'h52;
   localparam logic [7:0] ACK    = 8'h06;
   localparam logic [7:0] NAK    = 8'h15;

   typedef enum logic [3:0] {
      IDLE, CMD_ADDR, CMD_DATA,
`ifdef SERIAL_BUS_MASTER_CHECKSUM_EN
      CMD_SUM,
`endif
      BUS_WR, BUS_RD, RD_WAIT, TX_BYTE, TX_WAIT
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      byte_cnt_q, byte_cnt_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     data_q, data_d;
   logic            is_wr_q, is_wr_d;
   logic            pre_q, pre_d;
   logic [1:0]      rd_cnt_q, rd_cnt_d;
   logic [2:0]      tx_left_q, tx_left_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_wr_q, tx_wr_d;
   logic            rx_skip_q, rx_skip_d;
   logic            tx_skip_q, tx_skip_d;
   logic [TW-1:0]   to_cnt_q, to_cnt_d;
`ifdef SERIAL_BUS_MASTER_CHECKSUM_EN
   logic [7:0]      sum_q, sum_d;
`endif
   logic            accept;
   logic            to_expired;
   state_t          frame_done;

   assign accept     = rx_valid_i && !rx_skip_q;
   assign to_expired = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`ifdef SERIAL_BUS_MASTER_CHECKSUM_EN
   assign frame_done = CMD_SUM;
`else
   assign frame_done = is_wr_q ? BUS_WR : BUS_RD;
`endif

   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         state_q    <= IDLE;
         byte_cnt_q <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         is_wr_q    <= 1'b0;
         pre_q      <= 1'b0;
         rd_cnt_q   <= '0;
         tx_left_q  <= '0;
         tx_data_q  <= '0;
         tx_wr_q    <= 1'b0;
         rx_skip_q  <= 1'b0;
         tx_skip_q  <= 1'b0;
         to_cnt_q   <= '0;
`ifdef SERIAL_BUS_MASTER_CHECKSUM_EN
         sum_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         is_wr_q    <= is_wr_d;
         pre_q      <= pre_d;
         rd_cnt_q   <= rd_cnt_d;
         tx_left_q  <= tx_left_d;
         tx_data_q  <= tx_data_d;
         tx_wr_q    <= tx_wr_d;
         rx_skip_q  <= rx_skip_d;
         tx_skip_q  <= tx_skip_d;
         to_cnt_q   <= to_cnt_d;
`ifdef SERIAL_BUS_MASTER_CHECKSUM_EN
         sum_q      <= sum_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      addr_d     = addr_q;
      data_d     = data_q;
      is_wr_d    = is_wr_q;
      pre_d      = pre_q;
      rd_cnt_d   = rd_cnt_q;
      tx_left_d  = tx_left_q;
      tx_data_d  = tx_data_q;
      tx_wr_d    = 1'b0;
      to_cnt_d   = to_cnt_q;
`ifdef SERIAL_BUS_MASTER_CHECKSUM_EN
      sum_d      = sum_q;
`endif
      rx_rd_o    = 1'b0;
      bus_req_o  = 1'b0;
      we_o       = 1'b0;
      wr_mask_o  = 4'h0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               rx_rd_o    = 1'b1;
               byte_cnt_d = '0;
               to_cnt_d   = '0;
`ifdef SERIAL_BUS_MASTER_CHECKSUM_EN
               sum_d      = rx_data_i;
`endif
               if (rx_data_i == CMD_WR || rx_data_i == CMD_RD) begin
                  is_wr_d = (rx_data_i == CMD_WR);
                  state_d = CMD_ADDR;
               end else begin
                  data_d    = {NAK, 24'h0};
                  tx_left_d = 3'd1;
                  state_d   = TX_BYTE;
               end
            end
         end
         CMD_ADDR, CMD_DATA: begin
            if (accept) begin
               rx_rd_o    = 1'b1;
               to_cnt_d   = '0;
               byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef SERIAL_BUS_MASTER_CHECKSUM_EN
               sum_d      = sum_q ^ rx_data_i;
`endif
               if (state_q == CMD_ADDR) addr_d = {addr_q[23:0], rx_data_i};
               else                     data_d = {data_q[23:0], rx_data_i};
               if (byte_cnt_q == 2'd3) begin
                  pre_d   = 1'b1;
                  state_d = (state_q == CMD_ADDR && is_wr_q) ? CMD_DATA : frame_done;
               end
            end else if (to_expired) begin
               state_d = IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TW'(1);
            end
         end
`ifdef SERIAL_BUS_MASTER_CHECKSUM_EN
         CMD_SUM: begin
            if (accept) begin
               rx_rd_o = 1'b1;
               if (rx_data_i == sum_q) begin
                  state_d = is_wr_q ? BUS_WR : BUS_RD;
               end else begin
                  data_d    = {NAK, 24'h0};
                  tx_left_d = 3'd1;
                  state_d   = TX_BYTE;
               end
            end else if (to_expired) begin
               state_d = IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TW'(1);
            end
         end
`endif
         // pre_q gives the CPU one cycle of bus_req_o before the access itself
         BUS_WR: begin
            bus_req_o = 1'b1;
            if (pre_q) begin
               pre_d = 1'b0;
            end else begin
               we_o      = 1'b1;
               wr_mask_o = 4'hF;
               data_d    = {ACK, 24'h0};
               tx_left_d = 3'd1;
               state_d   = TX_BYTE;
            end
         end
         BUS_RD: begin
            bus_req_o = 1'b1;
            if (pre_q) begin
               pre_d = 1'b0;
            end else begin
               rd_cnt_d = '0;
               state_d  = RD_WAIT;
            end
         end
         RD_WAIT: begin
            bus_req_o = 1'b1;
            if (rd_cnt_q == 2'(READ_LATENCY - 1)) begin
               data_d    = data_in_i;
               tx_left_d = 3'd4;
               state_d   = TX_BYTE;
            end else begin
               rd_cnt_d = rd_cnt_q + 2'd1;
            end
         end
         TX_BYTE: begin
            if (!tx_busy_i) begin
               tx_wr_d   = 1'b1;
               tx_data_d = data_q[31:24];
               data_d    = {data_q[23:0], 8'h00};
               tx_left_d = tx_left_q - 3'd1;
               state_d   = TX_WAIT;
            end
         end
         TX_WAIT: begin
            if (!tx_wr_q && !tx_skip_q && !tx_busy_i) begin
               state_d = (tx_left_q == 3'd0) ? IDLE : TX_BYTE;
            end
         end
         default: state_d = IDLE;
      endcase
      rx_skip_d = rx_rd_o;
      tx_skip_d = tx_wr_q;
   end

   assign addr_o     = bus_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
   assign data_out_o = we_o ? data_q : 32'h0;
   assign tx_data_o  = tx_data_q;
   assign tx_wr_o    = tx_wr_q;
   assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_serial_bus_master.sv
// Directed bench for serial_bus_master: UART byte source/sink model plus bus monitor.
module tb_serial_bus_master;

   logic        clk = 1'b0;
   logic        reset_i = 1'b0;
   logic [7:0]  rx_data_i = '0;
   logic        rx_valid_i = 1'b0;
   logic        rx_rd_o;
   logic [7:0]  tx_data_o;
   logic        tx_wr_o;
   logic        tx_busy_i;
   logic        bus_req_o;
   logic [31:0] addr_o;
   logic        we_o;
   logic [3:0]  wr_mask_o;
   logic [31:0] data_out_o;
   logic [31:0] data_in_i = '0;
   logic        busy_o;

   int tests = 0;
   int fails = 0;

   logic [7:0]  txq[$];
   int          we_total = 0;
   int          req_total = 0;
   logic [31:0] we_addr = '0, we_data = '0, req_addr = '0;
   logic [3:0]  we_mask = '0;
   int          busy_cnt = 0;
   logic [7:0]  csum = '0;

   serial_bus_master #(.TIMEOUT_CYCLES(100), .READ_LATENCY(1)) dut (
      .clk(clk), .reset_i(reset_i),
      .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_rd_o(rx_rd_o),
      .tx_data_o(tx_data_o), .tx_wr_o(tx_wr_o), .tx_busy_i(tx_busy_i),
      .bus_req_o(bus_req_o), .addr_o(addr_o), .we_o(we_o), .wr_mask_o(wr_mask_o),
      .data_out_o(data_out_o), .data_in_i(data_in_i), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tx_wr_o) busy_cnt <= 6;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy_i = (busy_cnt != 0);

   always @(negedge clk) begin
      if (tx_wr_o) txq.push_back(tx_data_o);
      if (we_o) begin
         we_total++;
         we_addr = addr_o;
         we_data = data_out_o;
         we_mask = wr_mask_o;
      end
      if (bus_req_o) begin
         req_total++;
         req_addr = addr_o;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      bit got = 0;
      @(posedge clk); #1;
      rx_data_i  = b;
      rx_valid_i = 1'b1;
      csum       = csum ^ b;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (rx_rd_o) got = 1;
      end
      if (!got) begin
         fails++;
         $display("[TB] FAIL rx_handshake byte %h never consumed", b);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rx_valid_i = 1'b0;
   endtask

   task automatic end_frame();
`ifdef SERIAL_BUS_MASTER_CHECKSUM_EN
      send_byte(csum);
`endif
      csum = '0;
   endtask

   task automatic wait_idle(input string name);
      bit idle = 0;
      for (int i = 0; i < 1000 && !idle; i++) begin
         @(negedge clk);
         if (!busy_o) idle = 1;
      end
      if (!idle) begin
         fails++;
         $display("[TB] FAIL %s timeout waiting for busy_o low", name);
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if ({rx_rd_o, tx_wr_o, bus_req_o, we_o, busy_o} !== 5'b0) begin
         fails++;
         $display("[TB] FAIL reset_ctrl got %b exp 00000", {rx_rd_o, tx_wr_o, bus_req_o, we_o, busy_o});
      end
      tests++;
      if ({addr_o, data_out_o} !== 64'h0) begin
         fails++;
         $display("[TB] FAIL reset_bus got %h exp 0", {addr_o, data_out_o});
      end
      tests++;
      if ({tx_data_o, wr_mask_o} !== 12'h0) begin
         fails++;
         $display("[TB] FAIL reset_tx got %h exp 0", {tx_data_o, wr_mask_o});
      end
      @(posedge clk); #1;
      reset_i = 1'b1;
   endtask

   task automatic test_write(input logic [31:0] a, input logic [31:0] d, input string name);
      int base = txq.size();
      int we0  = we_total;
      csum = '0;
      send_byte(8'h57);
      for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
      for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
      end_frame();
      wait_idle(name);
      tests++;
      if (we_total - we0 !== 1) begin
         fails++;
         $display("[TB] FAIL %s_we_count got %0d exp 1", name, we_total - we0);
      end
      tests++;
      if ({we_addr, we_data, we_mask} !== {a[31:2], 2'b00, d, 4'hF}) begin
         fails++;
         $display("[TB] FAIL %s_access got %h %h %h exp %h %h f", name, we_addr, we_data, we_mask,
                  {a[31:2], 2'b00}, d);
      end
      tests++;
      if (txq.size() - base !== 1 || txq[base] !== 8'h06) begin
         fails++;
         $display("[TB] FAIL %s_reply got %0d bytes first %h exp 1 byte 06", name, txq.size() - base,
                  (txq.size() > base) ? txq[base] : 8'hxx);
      end
   endtask

   task automatic test_read(input logic [31:0] a, input logic [31:0] d, input string name);
      int base = txq.size();
      int we0  = we_total;
      int rq0  = req_total;
      logic [31:0] got = '0;
      data_in_i = d;
      csum = '0;
      send_byte(8'h52);
      for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
      end_frame();
      wait_idle(name);
      for (int i = 0; i < 4; i++)
         got = {got[23:0], (txq.size() > base + i) ? txq[base + i] : 8'hxx};
      tests++;
      if (txq.size() - base !== 4 || got !== d) begin
         fails++;
         $display("[TB] FAIL %s_reply got %0d bytes %h exp 4 bytes %h", name, txq.size() - base, got, d);
      end
      tests++;
      if (we_total !== we0 || req_total == rq0 || req_addr !== {a[31:2], 2'b00}) begin
         fails++;
         $display("[TB] FAIL %s_bus got we %0d req %0d addr %h exp we 0 req>0 addr %h", name,
                  we_total - we0, req_total - rq0, req_addr, {a[31:2], 2'b00});
      end
   endtask

   task automatic test_nak();
      int base = txq.size();
      int rq0  = req_total;
      send_byte(8'h41);
      csum = '0;
      wait_idle("nak");
      tests++;
      if (txq.size() - base !== 1 || txq[base] !== 8'h15 || req_total !== rq0) begin
         fails++;
         $display("[TB] FAIL nak got %0d bytes first %h req %0d exp 1 byte 15 req 0", txq.size() - base,
                  (txq.size() > base) ? txq[base] : 8'hxx, req_total - rq0);
      end
      test_write(32'h0000000C, 32'h12345678, "after_nak");
   endtask

   task automatic test_timeout();
      int base = txq.size();
      int we0  = we_total;
      int rq0  = req_total;
      send_byte(8'h57);
      send_byte(8'h00);
      send_byte(8'h00);
      csum = '0;
      repeat (50) @(negedge clk);
      tests++;
      if (busy_o !== 1'b1) begin
         fails++;
         $display("[TB] FAIL timeout_early got busy %b exp 1", busy_o);
      end
      repeat (100) @(negedge clk);
      tests++;
      if (busy_o !== 1'b0 || txq.size() !== base || we_total !== we0 || req_total !== rq0) begin
         fails++;
         $display("[TB] FAIL timeout_idle got busy %b tx %0d we %0d req %0d exp 0 0 0 0", busy_o,
                  txq.size() - base, we_total - we0, req_total - rq0);
      end
   endtask

   task automatic test_reset_mid();
      int base = txq.size();
      send_byte(8'h52);
      send_byte(8'h11);
      send_byte(8'h22);
      csum = '0;
      reset_i = 1'b0;
      #2;
      tests++;
      if ({busy_o, bus_req_o, rx_rd_o, tx_wr_o, addr_o} !== 36'h0) begin
         fails++;
         $display("[TB] FAIL reset_mid_outputs got %h exp 0", {busy_o, bus_req_o, rx_rd_o, tx_wr_o, addr_o});
      end
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      reset_i = 1'b1;
      repeat (150) @(negedge clk);
      tests++;
      if (txq.size() !== base) begin
         fails++;
         $display("[TB] FAIL reset_mid_no_reply got %0d bytes exp 0", txq.size() - base);
      end
      test_read(32'h00000004, 32'h01020304, "read_after_reset");
   endtask

`ifdef SERIAL_BUS_MASTER_CHECKSUM_EN
   task automatic test_checksum();
      int base, rq0;
      data_in_i = 32'hA5A55A5A;
      base = txq.size();
      csum = '0;
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
      send_byte(8'h56);
      wait_idle("cksum_ok");
      tests++;
      if (txq.size() - base !== 4 || txq[base] !== 8'hA5 || txq[base+3] !== 8'h5A) begin
         fails++;
         $display("[TB] FAIL cksum_ok got %0d bytes exp 4 bytes a5a55a5a", txq.size() - base);
      end
      base = txq.size();
      rq0  = req_total;
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
      send_byte(8'h57);
      csum = '0;
      wait_idle("cksum_bad");
      tests++;
      if (txq.size() - base !== 1 || txq[base] !== 8'h15 || req_total !== rq0) begin
         fails++;
         $display("[TB] FAIL cksum_bad got %0d bytes req %0d exp 1 byte 15 req 0", txq.size() - base,
                  req_total - rq0);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_write(32'h10000008, 32'hDEADBEEF, "write");
      test_read(32'h10000008, 32'hCAFEF00D, "read");
      test_read(32'h1000000B, 32'h89ABCDEF, "read_unaligned");
      test_nak();
      test_timeout();
      test_reset_mid();
`ifdef SERIAL_BUS_MASTER_CHECKSUM_EN
      test_checksum();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
